// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and command-word layout for the ALU command sequencer
// Command word layout (MSB..LSB): {opcode, A, B, tag}; the *_LSB offsets are counted from
// the top of the tag field, so a field sits at [TAG_W + *_LSB +: width].
package alu_pkg;
    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;
    localparam int B_LSB  = 0;
    localparam int A_LSB  = 4;
    localparam int OP_LSB = 8;
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    function automatic int cmd_w(input int tag_w);
        return 3 + 4 + 4 + tag_w;
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with occupancy count
// Ports: clk, rst_n (async active-low); push/din write when not full; pop reads the head
// (dout shows the head combinationally) when not empty; full, empty, count report occupancy.
module alu_cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // pointers are exactly AW bits wide, so increment wraps modulo DEPTH
    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, drives a combinational ALU and returns tagged results
// Ports: cmd_* valid/ready command channel {opcode,a,b,tag}; alu_opcode/alu_a/alu_b drive the
// ALU from registers, alu_out is its result; rsp_* valid/ready response channel
// {result,tag,err}; busy flags pending or in-flight work. clk, rst_n (async active-low).
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [2:0]       alu_opcode,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [7:0]       alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    localparam int CMD_W = cmd_w(TAG_W);
    localparam int CNT_W = $clog2(SETTLE_CYCLES+1);
    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [2:0]                   op_q, op_d;
    logic [3:0]                   a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]             tag_q, tag_d, rtag_q, rtag_d;
    logic [7:0]                   res_q, res_d;
    logic                         err_q, err_d, vld_q, vld_d, rdy_q;
    logic [CMD_W-1:0]             head;
    logic                         full, empty, load, dz;
    logic [$clog2(DEPTH+1)-1:0]   count;
    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .pop   (load),
        .din   ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // rdy_q keeps cmd_ready low throughout reset and for the first edge after it
    assign cmd_ready  = rdy_q && !full;
    assign busy       = state_q != IDLE || count != '0;
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = vld_q;
    assign rsp_result = res_q;
    assign rsp_tag    = rtag_q;
    assign rsp_err    = err_q;
    assign dz         = op_q == OP_DIV && b_q == 4'h0;
    // a new command is launched from IDLE, or straight out of RESP on the handshake edge
    assign load       = !empty && (state_q == IDLE || (state_q == RESP && vld_q && rsp_ready));
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        res_d   = res_q;
        rtag_d  = rtag_q;
        err_d   = err_q;
        vld_d   = vld_q;
        if (state_q == SETTLE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                res_d   = dz ? 8'hFF : alu_out;
                err_d   = dz;
                rtag_d  = tag_q;
                vld_d   = 1'b1;
                state_d = RESP;
            end
        end
        if (state_q == RESP && rsp_ready) begin
            vld_d   = 1'b0;
            state_d = IDLE;
        end
        if (load) begin
            op_d    = head[TAG_W+OP_LSB +: 3];
            a_d     = head[TAG_W+A_LSB +: 4];
            b_d     = head[TAG_W+B_LSB +: 4];
            tag_d   = head[TAG_W-1:0];
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            rtag_q  <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            rtag_q  <= rtag_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU
module tb_alu_cmd_sequencer;
    import alu_pkg::*;
    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] tag;
        logic [7:0] res;
        logic       err;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0, cmd_tag = '0;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_out;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_result;
    logic [3:0] rsp_tag;
    logic       hold_ready = 1'b0, rnd_ready = 1'b0, rand_mode = 1'b0;
    logic       s3_valid = 1'b0, s3_cmd_ready, s3_rsp_ready = 1'b1;
    logic [2:0] s3_opcode = '0, s3_alu_opcode;
    logic [3:0] s3_a = '0, s3_b = '0, s3_tag = '0, s3_alu_a, s3_alu_b, s3_rsp_tag;
    logic [7:0] s3_alu_out, s3_rsp_result;
    logic       s3_rsp_valid, s3_rsp_err, s3_busy;
    int         n_chk = 0, n_fail = 0;
    exp_t       exp_q[$];
    exp_t       e;

    always #5 clk = ~clk;

    // behavioural ALU: logic ops zero-extended, arithmetic on zero-extended 8-bit operands;
    // divide by zero returns 00 so the sequencer's FF override is observable
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_NOT:  return {4'h0, ~a};
            OP_AND:  return {4'h0, a & b};
            OP_OR:   return {4'h0, a | b};
            OP_XOR:  return {4'h0, a ^ b};
            OP_ADD:  return 8'(a) + 8'(b);
            OP_SUB:  return 8'(a) - 8'(b);
            OP_MUL:  return 8'(a) * 8'(b);
            default: return (b == 4'h0) ? 8'h00 : 8'(a) / 8'(b);
        endcase
    endfunction

    assign alu_out    = alu_f(alu_opcode, alu_a, alu_b);
    assign s3_alu_out = alu_f(s3_alu_opcode, s3_alu_a, s3_alu_b);
    assign rsp_ready  = rand_mode ? rnd_ready : hold_ready;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(s3_valid), .cmd_ready(s3_cmd_ready),
        .cmd_opcode(s3_opcode), .cmd_a(s3_a), .cmd_b(s3_b), .cmd_tag(s3_tag),
        .alu_opcode(s3_alu_opcode), .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_out(s3_alu_out),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_result(s3_rsp_result),
        .rsp_tag(s3_rsp_tag), .rsp_err(s3_rsp_err), .busy(s3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // called just after a rising edge; returns just after the edge that accepted the command
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] tag);
        int t = 0;
        exp_t x;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("cmd_ready_timeout", 1, 0);
        x.op = op; x.a = a; x.b = b; x.tag = tag;
        x.err = (op == OP_DIV && b == 4'h0);
        x.res = x.err ? 8'hFF : alu_f(op, a, b);
        exp_q.push_back(x);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #2;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // every cycle the response is presented it must match the oldest outstanding command,
    // and the ALU inputs must still carry that command's operands
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q[0];
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_err", rsp_err, e.err);
                chk("alu_opcode", alu_opcode, e.op);
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_ready", cmd_ready, 1);
        chk("s3_post_rst_ready", s3_cmd_ready, 1);

        // single ADD, latency
        hold_ready = 1'b1;
        send(OP_ADD, 4'h9, 4'h8, 4'd3);
        chk("lat_n0_valid", rsp_valid, 0);
        @(posedge clk); #2;
        chk("lat_n1_valid", rsp_valid, 0);
        chk("lat_n1_busy", busy, 1);
        @(posedge clk); #2;
        chk("lat_n2_valid", rsp_valid, 1);
        chk("add_result", rsp_result, 8'h11);
        drain();

        // divide by zero then normal divide
        send(OP_DIV, 4'h7, 4'h0, 4'd4);
        send(OP_DIV, 4'hC, 4'h3, 4'd5);
        drain();

        // backpressure with a full FIFO, then back-to-back release
        hold_ready = 1'b0;
        send(OP_MUL, 4'hF, 4'hF, 4'd6);
        send(OP_XOR, 4'h5, 4'hA, 4'd7);
        send(OP_OR, 4'h3, 4'h4, 4'd8);
        chk("full_cmd_ready", cmd_ready, 0);
        repeat (10) @(posedge clk);
        #2;
        chk("held_valid", rsp_valid, 1);
        chk("held_result", rsp_result, 8'hE1);
        hold_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("release_cycles", n, 5);

        // random stream with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 16; i++)
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(i));
        drain();
        rand_mode = 1'b0;
        @(posedge clk); #2;

        // reset while a command is settling with another still queued
        hold_ready = 1'b0;
        send(OP_ADD, 4'h1, 4'h2, 4'd1);
        send(OP_SUB, 4'h9, 4'h4, 4'd2);
        send(OP_AND, 4'hC, 4'hA, 4'd3);
        hold_ready = 1'b1;
        @(posedge clk); #2;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("after_rst_valid", rsp_valid, 0);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_ready", cmd_ready, 1);

        // long settle instance
        s3_opcode = OP_NOT; s3_a = 4'h5; s3_b = 4'h0; s3_tag = 4'd9; s3_valid = 1'b1;
        @(posedge clk); #2;
        s3_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #2;
            chk("s3_settle_valid", s3_rsp_valid, 0);
            chk("s3_settle_alu_a", s3_alu_a, 4'h5);
            chk("s3_settle_busy", s3_busy, 1);
        end
        @(posedge clk); #2;
        chk("s3_valid", s3_rsp_valid, 1);
        chk("s3_result", s3_rsp_result, 8'h0A);
        chk("s3_tag", s3_rsp_tag, 4'd9);
        chk("s3_err", s3_rsp_err, 0);
        chk("s3_alu_b", s3_alu_b, 4'h0);
        chk("s3_alu_op", s3_alu_opcode, OP_NOT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
